// File: rtl/chain_head_driver.sv
// Head of the shape-renderer daisy chain: emits the raster pixel stream and,
// between frames, serialises accepted shape commands into five-word program bursts.
module chain_head_driver #(
   parameter int          H_ACTIVE = 1280,
   parameter int          V_ACTIVE = 1024,
   parameter logic [31:0] BG_COLOR = 32'h0000_0000,
   parameter int          MAX_CMDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [10:0] cmd_shape_id,
   input  logic [11:0] cmd_x,
   input  logic [12:0] cmd_y,
   input  logic [11:0] cmd_w,
   input  logic [12:0] cmd_h,
   input  logic [31:0] cmd_color,
   output logic        frame_start,
   output logic        program_out,
   output logic [10:0] x_out,
   output logic [11:0] y_out,
   output logic [31:0] data_out
);

   localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
   localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
   localparam logic [7:0]  CNT_MAX  = 8'(MAX_CMDS);
   localparam bit          ONE_COL  = (H_ACTIVE == 1);
   localparam bit          ONE_PIX  = (H_ACTIVE == 1) && (V_ACTIVE == 1);

   typedef enum logic [1:0] {
      BOUNDARY,
      PROG,
      SCAN
   } state_t;

   state_t      state, state_nxt;
   logic [10:0] xcnt, xcnt_nxt;
   logic [11:0] ycnt, ycnt_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [7:0]  cmd_cnt, cmd_cnt_nxt;

   logic [10:0] held_shape, held_shape_nxt;
   logic [12:0] held_y, held_y_nxt;
   logic [11:0] held_w, held_w_nxt;
   logic [12:0] held_h, held_h_nxt;
   logic [31:0] held_color, held_color_nxt;

   logic        frame_start_nxt;
   logic        program_nxt;
   logic [10:0] x_nxt;
   logic [11:0] y_nxt;
   logic [31:0] data_nxt;

   logic        accept;
   logic [31:0] held_field;

   assign cmd_ready = !rst && (state == BOUNDARY) && (cmd_cnt < CNT_MAX);
   assign accept    = cmd_valid && cmd_ready;

   // Register ID 0 (x) is sent straight from the inputs on the accept edge, so only 1..4 are held.
   always_comb begin
      held_field = held_color;
      case (idx)
         3'd1:    held_field = {19'b0, held_y};
         3'd2:    held_field = {20'b0, held_w};
         3'd3:    held_field = {19'b0, held_h};
         default: held_field = held_color;
      endcase
   end

   always_comb begin
      state_nxt       = state;
      xcnt_nxt        = xcnt;
      ycnt_nxt        = ycnt;
      idx_nxt         = idx;
      cmd_cnt_nxt     = cmd_cnt;
      held_shape_nxt  = held_shape;
      held_y_nxt      = held_y;
      held_w_nxt      = held_w;
      held_h_nxt      = held_h;
      held_color_nxt  = held_color;
      frame_start_nxt = 1'b0;
      program_nxt     = 1'b0;
      x_nxt           = xcnt;
      y_nxt           = ycnt;
      data_nxt        = BG_COLOR;

      case (state)
         BOUNDARY: begin
            if (accept) begin
               program_nxt    = 1'b1;
               x_nxt          = cmd_shape_id;
               y_nxt          = 12'd0;
               data_nxt       = {20'b0, cmd_x};
               held_shape_nxt = cmd_shape_id;
               held_y_nxt     = cmd_y;
               held_w_nxt     = cmd_w;
               held_h_nxt     = cmd_h;
               held_color_nxt = cmd_color;
               cmd_cnt_nxt    = cmd_cnt + 8'd1;
               idx_nxt        = 3'd1;
               state_nxt      = PROG;
            end else begin
               // Pixel (0,0) goes out here so a command-free frame has no idle word.
               frame_start_nxt = 1'b1;
               x_nxt           = 11'd0;
               y_nxt           = 12'd0;
               if (ONE_PIX) begin
                  xcnt_nxt    = 11'd0;
                  ycnt_nxt    = 12'd0;
                  cmd_cnt_nxt = 8'd0;
                  state_nxt   = BOUNDARY;
               end else if (ONE_COL) begin
                  xcnt_nxt  = 11'd0;
                  ycnt_nxt  = 12'd1;
                  state_nxt = SCAN;
               end else begin
                  xcnt_nxt  = 11'd1;
                  ycnt_nxt  = 12'd0;
                  state_nxt = SCAN;
               end
            end
         end

         PROG: begin
            program_nxt = 1'b1;
            x_nxt       = held_shape;
            y_nxt       = {9'b0, idx};
            data_nxt    = held_field;
            idx_nxt     = idx + 3'd1;
            if (idx == 3'd4) begin
               state_nxt = BOUNDARY;
            end
         end

         SCAN: begin
            if (xcnt == X_LAST) begin
               xcnt_nxt = 11'd0;
               if (ycnt == Y_LAST) begin
                  ycnt_nxt    = 12'd0;
                  cmd_cnt_nxt = 8'd0;
                  state_nxt   = BOUNDARY;
               end else begin
                  ycnt_nxt = ycnt + 12'd1;
               end
            end else begin
               xcnt_nxt = xcnt + 11'd1;
            end
         end

         default: begin
            state_nxt = BOUNDARY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOUNDARY;
         xcnt        <= 11'd0;
         ycnt        <= 12'd0;
         idx         <= 3'd0;
         cmd_cnt     <= 8'd0;
         held_shape  <= 11'd0;
         held_y      <= 13'd0;
         held_w      <= 12'd0;
         held_h      <= 13'd0;
         held_color  <= 32'd0;
         frame_start <= 1'b0;
         program_out <= 1'b0;
         x_out       <= 11'd0;
         y_out       <= 12'd0;
         data_out    <= 32'd0;
      end else begin
         state       <= state_nxt;
         xcnt        <= xcnt_nxt;
         ycnt        <= ycnt_nxt;
         idx         <= idx_nxt;
         cmd_cnt     <= cmd_cnt_nxt;
         held_shape  <= held_shape_nxt;
         held_y      <= held_y_nxt;
         held_w      <= held_w_nxt;
         held_h      <= held_h_nxt;
         held_color  <= held_color_nxt;
         frame_start <= frame_start_nxt;
         program_out <= program_nxt;
         x_out       <= x_nxt;
         y_out       <= y_nxt;
         data_out    <= data_nxt;
      end
   end

endmodule

// File: tb/tb_chain_head_driver.sv
// Directed bench for chain_head_driver on a 4x3 raster with MAX_CMDS=2:
// raster order, program bursts, command limit, mid-scan requests and reset mid-burst.
module tb_chain_head_driver;

   localparam int          H  = 4;
   localparam int          V  = 3;
   localparam logic [31:0] BG = 32'hA5A5_1234;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [10:0] cmd_shape_id;
   logic [11:0] cmd_x;
   logic [12:0] cmd_y;
   logic [11:0] cmd_w;
   logic [12:0] cmd_h;
   logic [31:0] cmd_color;
   logic        frame_start;
   logic        program_out;
   logic [10:0] x_out;
   logic [11:0] y_out;
   logic [31:0] data_out;

   int checks = 0;
   int errors = 0;

   chain_head_driver #(
      .H_ACTIVE(H),
      .V_ACTIVE(V),
      .BG_COLOR(BG),
      .MAX_CMDS(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_shape_id(cmd_shape_id),
      .cmd_x(cmd_x),
      .cmd_y(cmd_y),
      .cmd_w(cmd_w),
      .cmd_h(cmd_h),
      .cmd_color(cmd_color),
      .frame_start(frame_start),
      .program_out(program_out),
      .x_out(x_out),
      .y_out(y_out),
      .data_out(data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [10:0] shape,
                                input logic [11:0] x, input logic [12:0] y,
                                input logic [11:0] w, input logic [12:0] h,
                                input logic [31:0] color);
      cmd_valid    = valid;
      cmd_shape_id = shape;
      cmd_x        = x;
      cmd_y        = y;
      cmd_w        = w;
      cmd_h        = h;
      cmd_color    = color;
   endtask

   // Packed as {program, frame_start, ready, x, y, data}.
   task automatic checkOutput(input string tag, input logic prog, input logic fs,
                              input logic rdy, input logic [10:0] x,
                              input logic [11:0] y, input logic [31:0] data);
      logic [57:0] observed;
      logic [57:0] expected;
      observed = {program_out, frame_start, cmd_ready, x_out, y_out, data_out};
      expected = {prog, fs, rdy, x, y, data};
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed prog=%b fs=%b rdy=%b x=%h y=%h d=%h, expected prog=%b fs=%b rdy=%b x=%h y=%h d=%h",
                tag, program_out, frame_start, cmd_ready, x_out, y_out, data_out,
                prog, fs, rdy, x, y, data);
      end
   endtask

   // Pixel p is (p % H, p / H); ready rises only after the last pixel of the frame.
   task automatic scanPixels(input int first, input int last);
      for (int p = first; p <= last; p++) begin
         step();
         checkOutput($sformatf("pixel%0d", p), 1'b0, (p == 0), (p == H * V - 1),
                     11'(p % H), 12'(p / H), BG);
      end
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 11'd0, 12'd0, 13'd0, 12'd0, 13'd0, 32'd0);
      step();
      step();
      checkOutput("reset", 1'b0, 1'b0, 1'b0, 11'd0, 12'd0, 32'd0);

      rst = 1'b0;
      #1;
      checkOutput("boundary_ready", 1'b0, 1'b0, 1'b1, 11'd0, 12'd0, 32'd0);

      $display("[TB] empty frames, period 12");
      scanPixels(0, 11);
      scanPixels(0, 5);

      $display("[TB] command raised at pixel (1,1) waits for the boundary");
      applyStimulus(1'b1, 11'd3, 12'd100, 13'd50, 12'd20, 13'd10, 32'hFF00_FF00);
      scanPixels(6, 11);
      step();
      checkOutput("burst3_x", 1'b1, 1'b0, 1'b0, 11'd3, 12'd0, 32'd100);
      applyStimulus(1'b0, 11'h155, 12'hAAA, 13'h0AAA, 12'h555, 13'h1555, 32'h1111_2222);
      step();
      checkOutput("burst3_y", 1'b1, 1'b0, 1'b0, 11'd3, 12'd1, 32'd50);
      step();
      checkOutput("burst3_w", 1'b1, 1'b0, 1'b0, 11'd3, 12'd2, 32'd20);
      step();
      checkOutput("burst3_h", 1'b1, 1'b0, 1'b0, 11'd3, 12'd3, 32'd10);
      step();
      checkOutput("burst3_color", 1'b1, 1'b0, 1'b1, 11'd3, 12'd4, 32'hFF00_FF00);
      scanPixels(0, 11);

      $display("[TB] back-to-back commands up to the limit of 2");
      applyStimulus(1'b1, 11'h7FF, 12'hFFF, 13'h1FFF, 12'hFFF, 13'h1ABC, 32'hDEAD_BEEF);
      step();
      checkOutput("burstA_x", 1'b1, 1'b0, 1'b0, 11'h7FF, 12'd0, 32'h0000_0FFF);
      applyStimulus(1'b1, 11'd2, 12'd1, 13'd2, 12'd3, 13'd4, 32'h1234_5678);
      step();
      checkOutput("burstA_y", 1'b1, 1'b0, 1'b0, 11'h7FF, 12'd1, 32'h0000_1FFF);
      step();
      checkOutput("burstA_w", 1'b1, 1'b0, 1'b0, 11'h7FF, 12'd2, 32'h0000_0FFF);
      step();
      checkOutput("burstA_h", 1'b1, 1'b0, 1'b0, 11'h7FF, 12'd3, 32'h0000_1ABC);
      step();
      checkOutput("burstA_color", 1'b1, 1'b0, 1'b1, 11'h7FF, 12'd4, 32'hDEAD_BEEF);
      step();
      checkOutput("burstB_x", 1'b1, 1'b0, 1'b0, 11'd2, 12'd0, 32'd1);
      applyStimulus(1'b1, 11'd5, 12'h0AB, 13'h0CD, 12'h0EF, 13'h012, 32'hCAFE_F00D);
      step();
      checkOutput("burstB_y", 1'b1, 1'b0, 1'b0, 11'd2, 12'd1, 32'd2);
      step();
      checkOutput("burstB_w", 1'b1, 1'b0, 1'b0, 11'd2, 12'd2, 32'd3);
      step();
      checkOutput("burstB_h", 1'b1, 1'b0, 1'b0, 11'd2, 12'd3, 32'd4);
      step();
      checkOutput("burstB_color_limit", 1'b1, 1'b0, 1'b0, 11'd2, 12'd4, 32'h1234_5678);
      scanPixels(0, 11);

      $display("[TB] reset in the middle of a burst");
      step();
      checkOutput("burstC_x", 1'b1, 1'b0, 1'b0, 11'd5, 12'd0, 32'h0000_00AB);
      step();
      checkOutput("burstC_y", 1'b1, 1'b0, 1'b0, 11'd5, 12'd1, 32'h0000_00CD);
      rst = 1'b1;
      applyStimulus(1'b0, 11'd0, 12'd0, 13'd0, 12'd0, 13'd0, 32'd0);
      step();
      checkOutput("reset_mid_burst", 1'b0, 1'b0, 1'b0, 11'd0, 12'd0, 32'd0);
      rst = 1'b0;
      scanPixels(0, 11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/chain_head_driver.md
Name: chain_head_driver

Overview:
- Head of the shape-renderer daisy chain.
- Generates the raster pixel stream that the chained renderers colour: x_out/y_out coordinates, with data_out seeded to the background colour and program_out low.
- Between frames it accepts shape commands over a valid/ready handshake and serialises each one into a five-word program burst: program_out=1, x_out=shape ID, y_out=register ID, data_out=value.
- Downstream renderers consume both kinds of traffic unchanged.

Parameters:
H_ACTIVE, 1280, pixels per line (1..2047)
V_ACTIVE, 1024, lines per frame (1..4095)
BG_COLOR, 32'h0000_0000, data_out value on every pixel word
MAX_CMDS, 16, maximum commands accepted per frame boundary (1..255)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_shape_id  input  11  target SHAPE_ID
cmd_x  input  12  centre x (register ID 0)
cmd_y  input  13  centre y (register ID 1)
cmd_w  input  12  width radius (register ID 2)
cmd_h  input  13  height radius (register ID 3)
cmd_color  input  32  fill colour (register ID 4)
frame_start  output  1  high on the cycle pixel (0,0) is presented
program_out  output  1  1 = program word, 0 = pixel word
x_out  output  11  pixel x, or shape ID
y_out  output  12  pixel y, or register ID
data_out  output  32  BG_COLOR, or register value

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk and rst).
- All outputs except cmd_ready are registered. cmd_ready is combinational: cmd_ready = !rst && state==BOUNDARY && cmd_cnt<MAX_CMDS.
- Reset value of every registered output is 0 (program_out, frame_start, x_out, y_out, data_out).
- Reset puts state in BOUNDARY with xcnt=ycnt=0, idx=0, cmd_cnt=0. Any held command is discarded.
- State BOUNDARY, at each edge:
  - Handshake: load word {program_out=1, x_out=cmd_shape_id, y_out=0, data_out=zero-extended cmd_x}. Capture all cmd_* into a holding register. cmd_cnt++, idx=1, go to PROG.
  - No handshake (cmd_valid low or cmd_cnt==MAX_CMDS): load pixel word {program_out=0, x_out=0, y_out=0, data_out=BG_COLOR, frame_start=1}. Set xcnt=1, ycnt=0, go to SCAN. If H_ACTIVE==1, use xcnt=0, ycnt=1 instead.
- State PROG, at each edge:
  - Load {1, held shape_id, idx, held field[idx]}. Fields for idx 1..4 are y, w, h, color; all are zero-extended to 32 bits.
  - idx++. After loading idx 4, go to BOUNDARY. Further commands can follow back to back, up to MAX_CMDS.
  - cmd_ready is low throughout PROG. Input changes during PROG do not affect the burst.
- State SCAN, at each edge:
  - Load pixel word (xcnt, ycnt, BG_COLOR), frame_start=0.
  - xcnt wraps at H_ACTIVE-1 and then increments ycnt.
  - Loading pixel (H_ACTIVE-1, V_ACTIVE-1) sends the state to BOUNDARY and clears cmd_cnt.
- Timing:
  - With no commands, the frame period is exactly H_ACTIVE*V_ACTIVE edges, with no idle words.
  - Each accepted command adds exactly 5 edges.
  - The first rising edge after rst deasserts is in BOUNDARY, so shapes can be programmed before the first frame.
- Reset mid-PROG:
  - The burst is abandoned and the next edge loads zeros.
  - Register IDs already emitted stay written in the renderer. This is acceptable; the host re-sends the command.
- cmd_valid high during SCAN: the command waits, with no ready, until BOUNDARY. The source must hold cmd_* stable while waiting.
- Command field values wider than the renderer register are transported unchanged. Truncation is the renderer's concern.

Test Plan:
1. H_ACTIVE=4, V_ACTIVE=3, cmd_valid=0, rst for 2 cycles then released -> first word is (0,0), BG, frame_start=1. Then 11 pixel words in raster order, then (0,0) with frame_start=1 again: period 12.
2. Same params; present shape_id=3, x=100, y=50, w=20, h=10, color=32'hFF00FF00 before reset release -> words (3,0,100), (3,1,50), (3,2,20), (3,3,10), (3,4,FF00FF00), all program_out=1. Then pixel (0,0) with frame_start=1. Frame period is 17 edges.
3. MAX_CMDS=2, cmd_valid held high with changing data -> exactly 2 bursts (10 words) per boundary, then cmd_ready=0 and a full 12-pixel scan. Repeats each frame; cmd_cnt resets each boundary.
4. cmd_valid raised at pixel (1,1) mid-scan -> cmd_ready stays 0 and no program words appear until after (3,2). The burst then starts on the next edge.
5. rst asserted during the edge after word (5,1,…) of a burst -> next outputs all 0. After release: BOUNDARY, then pixel (0,0) if no command is pending.
6. Default params, no commands -> frame_start pulses exactly every 1,310,720 cycles, and program_out is never 1.
